// File: rtl/leg_pkg.sv
// Shared types for the decode-to-reservation-station path: the decoded
// instruction bundle and the station codes it can carry.
package leg_pkg;

  localparam int RS_W = 4;

  // Station codes; the field stays a plain vector so unknown codes can be carried.
  typedef enum logic [RS_W-1:0] {
    RS_NONE   = 4'd0,
    RS_ALU    = 4'd1,
    RS_MULDIV = 4'd2,
    RS_BRANCH = 4'd3,
    RS_LSU    = 4'd4
  } rs_station_e;

  typedef struct packed {
    logic [5:0]      operation;
    logic [4:0]      register_target;
    logic [4:0]      register_1;
    logic [4:0]      register_2;
    logic [15:0]     immediate;
    logic [RS_W-1:0] rs_station;
    logic [5:0]      alu_fn;
    logic            has_register_1;
    logic            has_register_2;
    logic            has_target;
  } dec_instr_t;

endpackage

// File: rtl/dispatch_fifo.sv
// In-order instruction buffer: synchronous FIFO with occupancy count and a
// synchronous flush that empties it and discards any same-cycle write.
module dispatch_fifo #(
  parameter  int DATA_W = 50,
  parameter  int DEPTH  = 4,
  localparam int AW     = $clog2(DEPTH),
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              push;
  logic              pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign push    = wr_en && !full && !flush;
  assign pop     = rd_en && !empty && !flush;
  assign rd_data = mem[rd_ptr];

  // Entry storage holds data only, so it carries no reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // Pointers wrap naturally at DEPTH (power of two); count tracks occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

endmodule

// File: rtl/rs_dispatch_unit.sv
// Dispatch stage: buffers decoded instructions in order and issues the head
// to its reservation station when that station has a free-slot credit.
// Unknown station codes are dropped from the head with a one-cycle flag.
module rs_dispatch_unit
  import leg_pkg::*;
#(
  parameter  int NUM_RS   = 4,
  parameter  int RS_DEPTH = 4,
  parameter  int Q_DEPTH  = 4,
  localparam int CW       = $clog2(RS_DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  dec_instr_t           in_instr,
  output logic [NUM_RS-1:0]    disp_valid,
  output dec_instr_t           disp_instr,
  input  logic [NUM_RS-1:0]    rs_free,
  output logic                 illegal,
  output logic [NUM_RS*CW-1:0] credits
);

  localparam int QCW = $clog2(Q_DEPTH + 1);

  dec_instr_t         head;
  logic [QCW-1:0]     fifo_count;
  logic               fifo_full;
  logic               fifo_empty;
  logic               head_avail;
  logic               pop;
  logic [NUM_RS-1:0]  station_sel;
  logic [NUM_RS-1:0]  issue_vec;
  logic [CW-1:0]      credit [NUM_RS];

  // Free/issue update with saturation at RS_DEPTH; underflow cannot occur
  // because an issue requires a non-zero registered credit.
  function automatic logic [CW-1:0] credit_update(input logic [CW-1:0] cur,
                                                  input logic          freed,
                                                  input logic          taken);
    logic [CW:0] sum;
    sum = {1'b0, cur} + (CW+1)'(freed) - (CW+1)'(taken);
    if (sum > (CW+1)'(RS_DEPTH)) return CW'(RS_DEPTH);
    return sum[CW-1:0];
  endfunction

  dispatch_fifo #(
    .DATA_W ($bits(dec_instr_t)),
    .DEPTH  (Q_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
    .wr_en   (in_valid),
    .wr_data (in_instr),
    .rd_en   (pop),
    .rd_data (head),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // A flush cycle suppresses issue and drop so nothing leaves the buffer.
  assign head_avail = !fifo_empty && !flush;
  assign in_ready   = !fifo_full;
  assign disp_instr = fifo_empty ? '0 : head;

  // One-hot decode of the head's station code; codes outside 1..NUM_RS select nothing.
  always_comb begin
    station_sel = '0;
    for (int k = 0; k < NUM_RS; k++) begin
      station_sel[k] = (head.rs_station == RS_W'(k + 1));
    end
  end

  // Issue the head only to a selected station holding at least one credit.
  always_comb begin
    issue_vec = '0;
    for (int k = 0; k < NUM_RS; k++) begin
      issue_vec[k] = head_avail && station_sel[k] && (credit[k] != '0);
    end
  end

  assign disp_valid = issue_vec;
  assign illegal    = head_avail && !(|station_sel);
  assign pop        = (|issue_vec) || illegal;

  // Per-station credit counters; a flush leaves them alone since slots return via rs_free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUM_RS; k++) credit[k] <= CW'(RS_DEPTH);
    end else begin
      for (int k = 0; k < NUM_RS; k++) begin
        credit[k] <= credit_update(credit[k], rs_free[k], issue_vec[k]);
      end
    end
  end

  // Pack the counters for the debug port, station 1 in the low bits.
  always_comb begin
    credits = '0;
    for (int k = 0; k < NUM_RS; k++) credits[k*CW +: CW] = credit[k];
  end

  // Catch a station returning a slot it never received, and buffer overrun.
  always @(posedge clk) begin
    if (!rst) begin
      for (int k = 0; k < NUM_RS; k++) begin
        assert (!(rs_free[k] && !issue_vec[k] && credit[k] == CW'(RS_DEPTH)));
      end
      assert (fifo_count <= QCW'(Q_DEPTH));
    end
  end

endmodule

// File: tb/tb_rs_dispatch_unit.sv
module tb_rs_dispatch_unit;
  import leg_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  dec_instr_t  in_instr;
  logic [3:0]  disp_valid;
  dec_instr_t  disp_instr;
  logic [3:0]  rs_free;
  logic        illegal;
  logic [11:0] credits;

  int checks = 0;
  int errors = 0;

  // Reference model state: queue of buffered bundles and integer credits.
  dec_instr_t  mq[$];
  int          mcred[4];
  logic [3:0]  exp_valid;
  logic        exp_ill;
  logic        exp_ready;
  dec_instr_t  exp_instr;
  logic [11:0] exp_cred;

  rs_dispatch_unit #(.NUM_RS(4), .RS_DEPTH(4), .Q_DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_instr   (in_instr),
    .disp_valid (disp_valid),
    .disp_instr (disp_instr),
    .rs_free    (rs_free),
    .illegal    (illegal),
    .credits    (credits)
  );

  always #5 clk = ~clk;

  function automatic dec_instr_t mk(input logic [3:0] st, input logic [4:0] rt);
    dec_instr_t r;
    r = '0;
    r.operation       = 6'h09;
    r.register_target = rt;
    r.register_1      = 5'd1;
    r.immediate       = 16'h0010;
    r.rs_station      = st;
    r.alu_fn          = 6'h21;
    r.has_register_1  = 1'b1;
    r.has_target      = 1'b1;
    return r;
  endfunction

  // Expected outputs for this cycle from the queue/credit model.
  function automatic void model_expect(input logic fl);
    int s;
    exp_valid = '0;
    exp_ill   = 1'b0;
    exp_ready = (mq.size() < 4);
    exp_instr = '0;
    exp_cred  = '0;
    for (int k = 0; k < 4; k++) exp_cred[k*3 +: 3] = 3'(mcred[k]);
    if (mq.size() > 0) begin
      exp_instr = mq[0];
      s = int'(mq[0].rs_station);
      if (!fl) begin
        if (s >= 1 && s <= 4) begin
          if (mcred[s-1] > 0) exp_valid[s-1] = 1'b1;
        end else begin
          exp_ill = 1'b1;
        end
      end
    end
  endfunction

  function automatic void model_advance(input logic iv, input dec_instr_t ins,
                                        input logic [3:0] fr, input logic fl);
    for (int k = 0; k < 4; k++) begin
      mcred[k] = mcred[k] + int'(fr[k]) - int'(exp_valid[k]);
      if (mcred[k] > 4) mcred[k] = 4;
    end
    if (fl) begin
      mq.delete();
    end else begin
      if (exp_valid != '0 || exp_ill) void'(mq.pop_front());
      if (iv && exp_ready) mq.push_back(ins);
    end
  endfunction

  task automatic drive(input logic v, input dec_instr_t i, input logic [3:0] fr, input logic fl);
    in_valid = v;
    in_instr = i;
    rs_free  = fr;
    flush    = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    drive(1'b0, '0, 4'b0, 1'b0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if ({in_ready, disp_valid, illegal} !== {1'b1, 4'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_ctrl: got ready=%b valid=%b illegal=%b, want 1 0000 0", in_ready, disp_valid, illegal);
    end
    checks++;
    if (credits !== 12'h924) begin
      errors++;
      $display("FAIL reset_credits: got %h want 924", credits);
    end
    checks++;
    if (disp_instr !== dec_instr_t'('0)) begin
      errors++;
      $display("FAIL reset_instr: got %h want 0", disp_instr);
    end
  endtask

  task automatic test_single_issue();
    dec_instr_t addiu;
    do_reset();
    addiu = mk(RS_ALU, 5'd3);
    drive(1'b1, addiu, 4'b0, 1'b0);
    #1;
    checks++;
    if (disp_valid !== 4'b0000) begin
      errors++;
      $display("FAIL single_same_cycle: got valid=%b want 0000", disp_valid);
    end
    tick();
    drive(1'b0, '0, 4'b0, 1'b0);
    #1;
    checks++;
    if (disp_valid !== 4'b0001 || disp_instr !== addiu) begin
      errors++;
      $display("FAIL single_issue: got valid=%b instr=%h want 0001 %h", disp_valid, disp_instr, addiu);
    end
    tick();
    #1;
    checks++;
    if (credits[2:0] !== 3'd3 || disp_valid !== 4'b0) begin
      errors++;
      $display("FAIL single_credit: got credit1=%0d valid=%b want 3 0000", credits[2:0], disp_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] want;
    do_reset();
    for (int c = 0; c < 7; c++) begin
      drive(c < 5, mk(RS_ALU, 5'(c)), 4'b0, 1'b0);
      #1;
      want = (c >= 1 && c <= 4) ? 4'b0001 : 4'b0000;
      checks++;
      if (disp_valid !== want || (want != 0 && disp_instr.register_target !== 5'(c - 1))) begin
        errors++;
        $display("FAIL b2b_cycle%0d: got valid=%b rt=%0d want %b rt=%0d", c, disp_valid,
                 disp_instr.register_target, want, c - 1);
      end
      tick();
    end
    checks++;
    if (credits[2:0] !== 3'd0) begin
      errors++;
      $display("FAIL b2b_stall_credit: got %0d want 0", credits[2:0]);
    end
    drive(1'b0, '0, 4'b0001, 1'b0);
    #1;
    checks++;
    if (disp_valid !== 4'b0000) begin
      errors++;
      $display("FAIL b2b_free_cycle: got valid=%b want 0000", disp_valid);
    end
    tick();
    drive(1'b0, '0, 4'b0, 1'b0);
    #1;
    checks++;
    if (disp_valid !== 4'b0001 || disp_instr.register_target !== 5'd4) begin
      errors++;
      $display("FAIL b2b_fifth: got valid=%b rt=%0d want 0001 rt=4", disp_valid, disp_instr.register_target);
    end
    tick();
    #1;
    checks++;
    if (credits[2:0] !== 3'd0 || disp_valid !== 4'b0) begin
      errors++;
      $display("FAIL b2b_end: got credit1=%0d valid=%b want 0 0000", credits[2:0], disp_valid);
    end
  endtask

  task automatic test_same_cycle_free();
    do_reset();
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, mk(RS_LSU, 5'(c)), 4'b0, 1'b0);
      #1;
      if (c > 0) begin
        checks++;
        if (disp_valid !== 4'b1000) begin
          errors++;
          $display("FAIL lsu_issue%0d: got valid=%b want 1000", c, disp_valid);
        end
      end
      tick();
    end
    checks++;
    if (credits[11:9] !== 3'd2) begin
      errors++;
      $display("FAIL lsu_pre: got credit4=%0d want 2", credits[11:9]);
    end
    drive(1'b0, '0, 4'b1000, 1'b0);
    #1;
    checks++;
    if (disp_valid !== 4'b1000) begin
      errors++;
      $display("FAIL lsu_both: got valid=%b want 1000", disp_valid);
    end
    tick();
    drive(1'b0, '0, 4'b0, 1'b0);
    #1;
    checks++;
    if (credits[11:9] !== 3'd2 || disp_valid !== 4'b0) begin
      errors++;
      $display("FAIL lsu_post: got credit4=%0d valid=%b want 2 0000", credits[11:9], disp_valid);
    end
  endtask

  task automatic test_illegal();
    do_reset();
    drive(1'b1, mk(RS_NONE, 5'd7), 4'b0, 1'b0);
    tick();
    drive(1'b1, mk(RS_MULDIV, 5'd8), 4'b0, 1'b0);
    #1;
    checks++;
    if (illegal !== 1'b1 || disp_valid !== 4'b0) begin
      errors++;
      $display("FAIL illegal_drop: got illegal=%b valid=%b want 1 0000", illegal, disp_valid);
    end
    tick();
    drive(1'b0, '0, 4'b0, 1'b0);
    #1;
    checks++;
    if (illegal !== 1'b0 || disp_valid !== 4'b0010 || credits !== 12'h924) begin
      errors++;
      $display("FAIL illegal_next: got illegal=%b valid=%b credits=%h want 0 0010 924",
               illegal, disp_valid, credits);
    end
    tick();
    #1;
    checks++;
    if (credits !== 12'h91C) begin
      errors++;
      $display("FAIL illegal_credits: got %h want 91c", credits);
    end
  endtask

  task automatic test_flush();
    do_reset();
    for (int c = 0; c < 8; c++) begin
      drive(1'b1, mk(RS_BRANCH, 5'(c)), 4'b0, 1'b0);
      tick();
    end
    drive(1'b1, mk(RS_ALU, 5'd30), 4'b0, 1'b1);
    #1;
    checks++;
    if (in_ready !== 1'b0 || credits[8:6] !== 3'd0 || disp_valid !== 4'b0) begin
      errors++;
      $display("FAIL flush_full: got ready=%b credit3=%0d valid=%b want 0 0 0000",
               in_ready, credits[8:6], disp_valid);
    end
    tick();
    drive(1'b0, '0, 4'b0, 1'b0);
    #1;
    checks++;
    if (in_ready !== 1'b1 || disp_valid !== 4'b0 || illegal !== 1'b0 ||
        disp_instr !== dec_instr_t'('0) || credits[8:6] !== 3'd0) begin
      errors++;
      $display("FAIL flush_after: got ready=%b valid=%b illegal=%b instr=%h credit3=%0d",
               in_ready, disp_valid, illegal, disp_instr, credits[8:6]);
    end
    drive(1'b1, mk(RS_ALU, 5'd9), 4'b0, 1'b0);
    tick();
    drive(1'b0, '0, 4'b0, 1'b1);
    #1;
    checks++;
    if (disp_valid !== 4'b0) begin
      errors++;
      $display("FAIL flush_gate: got valid=%b want 0000", disp_valid);
    end
    tick();
    drive(1'b0, '0, 4'b0, 1'b0);
    #1;
    checks++;
    if (disp_valid !== 4'b0 || credits[2:0] !== 3'd4) begin
      errors++;
      $display("FAIL flush_gate_after: got valid=%b credit1=%0d want 0000 4", disp_valid, credits[2:0]);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, mk(RS_ALU, 5'(c)), 4'b0, 1'b0);
      tick();
    end
    drive(1'b0, '0, 4'b0, 1'b0);
    #1;
    checks++;
    if (credits[2:0] !== 3'd2 || disp_valid !== 4'b0001) begin
      errors++;
      $display("FAIL arst_pre: got credit1=%0d valid=%b want 2 0001", credits[2:0], disp_valid);
    end
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({in_ready, disp_valid, illegal} !== {1'b1, 4'b0, 1'b0} || credits !== 12'h924 ||
        disp_instr !== dec_instr_t'('0)) begin
      errors++;
      $display("FAIL arst_mid: got ready=%b valid=%b illegal=%b credits=%h instr=%h",
               in_ready, disp_valid, illegal, credits, disp_instr);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_random();
    dec_instr_t r;
    logic [63:0] w;
    logic [3:0]  fr;
    logic        iv;
    logic        fl;
    do_reset();
    mq.delete();
    for (int k = 0; k < 4; k++) mcred[k] = 4;
    for (int c = 0; c < 600; c++) begin
      w = {$urandom(), $urandom()};
      r = w[49:0];
      if ($urandom_range(0, 7) == 0)
        r.rs_station = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(5, 15));
      else
        r.rs_station = 4'($urandom_range(1, 4));
      iv = ($urandom_range(0, 3) != 0);
      fl = ($urandom_range(0, 29) == 0);
      fr = '0;
      for (int k = 0; k < 4; k++)
        if (mcred[k] < 4 && $urandom_range(0, 2) == 0) fr[k] = 1'b1;
      drive(iv, r, fr, fl);
      #1;
      model_expect(fl);
      checks++;
      if ({in_ready, disp_valid, illegal, credits} !== {exp_ready, exp_valid, exp_ill, exp_cred}) begin
        errors++;
        $display("FAIL rand_ctrl c%0d: got rdy=%b v=%b ill=%b cr=%h want rdy=%b v=%b ill=%b cr=%h", c,
                 in_ready, disp_valid, illegal, credits, exp_ready, exp_valid, exp_ill, exp_cred);
      end
      checks++;
      if (disp_instr !== exp_instr) begin
        errors++;
        $display("FAIL rand_instr c%0d: got %h want %h", c, disp_instr, exp_instr);
      end
      model_advance(iv, r, fr, fl);
      tick();
    end
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, '0, 4'b0, 1'b0);
    test_reset();
    test_single_issue();
    test_back_to_back();
    test_same_cycle_free();
    test_illegal();
    test_flush();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rs_dispatch_unit.md
Name: rs_dispatch_unit

Overview:
- Sits between the instruction decoder and the reservation stations. It buffers decoded instructions in a small in-order FIFO and issues the head entry to the station selected by its rs_station field.
- Tracks free slots per station with credit counters and stalls the head while its station has no credit.
- Drops instructions whose station code is unknown and flags them. Issue is strictly in order: the head blocks all younger entries.

Parameters:
- NUM_RS, 4, number of reservation stations; codes 1..NUM_RS are valid.
- RS_DEPTH, 4, slots per station; the initial credit value.
- Q_DEPTH, 4, instruction buffer entries; must be a power of 2.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- flush  in  1  discard every buffered instruction
- in_valid  in  1  decoded instruction present
- in_ready  out  1  buffer can accept
- in_instr  in  dec_instr_t  decoded bundle: operation, register_target, register_1, register_2, immediate, rs_station, alu_fn, has_register_1, has_register_2, has_target
- disp_valid  out  NUM_RS  one-hot issue strobe, bit k-1 = station k
- disp_instr  out  dec_instr_t  head bundle, shared by all stations
- rs_free  in  NUM_RS  per-station slot-release pulses; several may be set in one cycle
- illegal  out  1  one-cycle pulse: head had rs_station 0 or >NUM_RS and was dropped
- credits  out  NUM_RS*CW  packed credit counters, for debug; CW = $clog2(RS_DEPTH+1)

Behaviour:
- Reset (async assert, sync release) values:
  - FIFO empty, pointers 0
  - in_ready=1, disp_valid=0, illegal=0
  - all credits=RS_DEPTH
  - disp_instr=0
- Enqueue: in_valid && in_ready at edge N writes the entry. in_ready = !full, registered from the count; no write-through when full. The entry is visible at the head and can issue at edge N+1 at the earliest.
- Head issue is combinational from registered state. With head station s, the head issues when the FIFO is non-empty, s is in 1..NUM_RS, and credit[s]>0. Then:
  - disp_valid[s-1]=1 and disp_instr=head in that cycle.
  - The head pops at the edge.
  - credit[s] decrements at the edge.
- Stations never back-pressure: a disp_valid pulse is a committed transfer.
- Stall: when credit[s]==0 the head stays put, disp_valid=0, and younger entries wait.
- Illegal head (s==0 or s>NUM_RS): pops in one cycle with illegal=1 and disp_valid=0. No credit changes.
- Credit update per station k, per cycle: credit_next = credit + rs_free[k-1] - issue_k.
  - A free and an issue on the same station in the same cycle leave the count unchanged. Issue is permitted at credit 0 only if rs_free is asserted that same cycle? No: issue requires credit>0 as registered; the free is counted at the edge.
  - rs_free at credit==RS_DEPTH is a protocol error: saturate at RS_DEPTH, and a simulation assertion fires.
- Throughput: 1 issue or drop per cycle. Enqueue and pop in the same cycle keep the count; this is legal when full because in_ready was already 0.
- Pointers wrap modulo Q_DEPTH. full = count==Q_DEPTH, empty = count==0.
- Flush, synchronous:
  - At the edge: pointers and count go to 0, and any same-cycle enqueue is discarded.
  - disp_valid and illegal are forced 0 during the flush cycle, so nothing is issued.
  - Credits are NOT reset; stations return them via rs_free.
- Reset mid-operation: everything returns to reset values immediately, including credits. Pending entries are lost.

Decomposition:
- Shared package leg_pkg:
  - dec_instr_t packed struct, field widths 6/5/5/5/16/4/6/1/1/1
  - RS_NONE=0, RS_ALU=1, RS_MULDIV=2, RS_BRANCH=3, RS_LSU=4
- One sub-module: dispatch_fifo, a parameterised sync FIFO with count, full, empty and flush.
- Credit counters and issue logic stay in the top level.

Test Plan:
- Reset, then enqueue addiu bundle (rs_station=1, register_target=3): disp_valid=4'b0001 on the cycle after acceptance; credit[1] goes 4→3.
- Enqueue 5 ALU ops back-to-back with rs_free=0: 4 issue in consecutive cycles, the 5th stalls with credit[1]=0. Pulse rs_free[0]: the 5th issues on the next cycle and credit ends at 0.
- Same cycle, credit[4]=2: LSU head issues and rs_free[3]=1 → credit[4] stays 2.
- Enqueue rs_station=0, then rs_station=2: illegal pulses 1 cycle, then disp_valid=4'b0010 next cycle; credits unchanged by the drop.
- Fill FIFO to 4 with station-3 credit 0: in_ready=0. Assert flush with in_valid=1: the FIFO is empty the next cycle, no disp_valid, in_ready=1, credit[3] still 0.
- Assert rst asynchronously mid-stream (between edges): outputs go to reset values before the next edge and all credits read RS_DEPTH=4.
